// File: rtl/buck_pwm_generator.sv
// Two-channel interleaved buck PWM generator: free-running 4 us timebases,
// per-period on-time latch with clamp, dead-time gate decode, enable/fault sequencing.
module buck_pwm_generator #(
  parameter int PERIOD = 400,
  parameter int PHASE  = 200,
  parameter int MAX_ON = 200,
  parameter int DEAD   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fault,
  input  logic [15:0] inductor_charging_time,
  output logic [15:0] timer_buck_4us_0,
  output logic [15:0] timer_buck_4us_1,
  output logic        gate_hi_0,
  output logic        gate_lo_0,
  output logic        gate_hi_1,
  output logic        gate_lo_1,
  output logic        running,
  output logic        fault_latched
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [15:0] LAST   = 16'(PERIOD - 1);
  localparam logic [15:0] LO_END = 16'(PERIOD - DEAD);

  state_t      state;
  state_t      state_nxt;
  logic        active_1;
  logic        active_1_nxt;
  logic        run_nxt;
  logic [15:0] ton_0;
  logic [15:0] ton_1;
  logic [15:0] ton_0_nxt;
  logic [15:0] ton_1_nxt;
  logic [15:0] clamped;
  logic [15:0] t0_nxt;
  logic [15:0] t1_nxt;

  function automatic state_t next_state(input state_t s, input logic en, input logic flt,
                                        input logic wrap);
    state_t n;
    case (s)
      IDLE:    n = (en && !flt) ? ARM : IDLE;
      ARM: begin
        if (flt)       n = FAULT;
        else if (!en)  n = IDLE;
        else if (wrap) n = RUN;
        else           n = ARM;
      end
      RUN: begin
        if (flt)       n = FAULT;
        else if (!en)  n = IDLE;
        else           n = RUN;
      end
      FAULT:   n = (!en && !flt) ? IDLE : FAULT;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  function automatic logic hi_decode(input logic act, input logic [15:0] ton,
                                     input logic [15:0] t);
    return act && (ton != 16'd0) && (t < ton);
  endfunction

  function automatic logic lo_decode(input logic act, input logic [15:0] ton,
                                     input logic [15:0] t);
    return act && (ton != 16'd0) && ({1'b0, t} >= ({1'b0, ton} + 17'(DEAD))) && (t < LO_END);
  endfunction

  // Gates are decoded from next-cycle timer/on-time so they line up with the timer outputs.
  always_comb begin
    clamped      = (inductor_charging_time > 16'(MAX_ON)) ? 16'(MAX_ON) : inductor_charging_time;
    t0_nxt       = (timer_buck_4us_0 == LAST) ? 16'd0 : timer_buck_4us_0 + 16'd1;
    t1_nxt       = (timer_buck_4us_1 == LAST) ? 16'd0 : timer_buck_4us_1 + 16'd1;
    ton_0_nxt    = (timer_buck_4us_0 == LAST) ? clamped : ton_0;
    ton_1_nxt    = (timer_buck_4us_1 == LAST) ? clamped : ton_1;
    state_nxt    = next_state(state, enable, fault, timer_buck_4us_0 == LAST);
    run_nxt      = (state_nxt == RUN);
    active_1_nxt = run_nxt && (active_1 || ((state == RUN) && (timer_buck_4us_1 == LAST)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      timer_buck_4us_0 <= 16'd0;
      timer_buck_4us_1 <= 16'(PHASE);
      ton_0            <= 16'd0;
      ton_1            <= 16'd0;
      active_1         <= 1'b0;
      gate_hi_0        <= 1'b0;
      gate_lo_0        <= 1'b0;
      gate_hi_1        <= 1'b0;
      gate_lo_1        <= 1'b0;
      running          <= 1'b0;
      fault_latched    <= 1'b0;
    end else begin
      state            <= state_nxt;
      timer_buck_4us_0 <= t0_nxt;
      timer_buck_4us_1 <= t1_nxt;
      ton_0            <= ton_0_nxt;
      ton_1            <= ton_1_nxt;
      active_1         <= active_1_nxt;
      gate_hi_0        <= hi_decode(run_nxt, ton_0_nxt, t0_nxt);
      gate_lo_0        <= lo_decode(run_nxt, ton_0_nxt, t0_nxt);
      gate_hi_1        <= hi_decode(active_1_nxt, ton_1_nxt, t1_nxt);
      gate_lo_1        <= lo_decode(active_1_nxt, ton_1_nxt, t1_nxt);
      running          <= run_nxt;
      fault_latched    <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_buck_pwm_generator.sv
// Randomized scoreboard bench for buck_pwm_generator: a cycle-count based reference
// model queues expected outputs, a negedge monitor pops and compares them.
module tb_buck_pwm_generator;

  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fault = 1'b0;
  logic [15:0] inductor_charging_time = 16'd0;
  logic [15:0] timer_buck_4us_0;
  logic [15:0] timer_buck_4us_1;
  logic        gate_hi_0, gate_lo_0, gate_hi_1, gate_lo_1, running, fault_latched;

  buck_pwm_generator dut (
    .clk(clk), .rst(rst), .enable(enable), .fault(fault),
    .inductor_charging_time(inductor_charging_time),
    .timer_buck_4us_0(timer_buck_4us_0), .timer_buck_4us_1(timer_buck_4us_1),
    .gate_hi_0(gate_hi_0), .gate_lo_0(gate_lo_0),
    .gate_hi_1(gate_hi_1), .gate_lo_1(gate_lo_1),
    .running(running), .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] t0;
    logic [15:0] t1;
    logic        hi0, lo0, hi1, lo1, run, flt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // reference model state: cycles since reset, operating mode, latched on-times
  int n = 0;
  int mode = M_IDLE;
  int ton0 = 0, ton1 = 0;
  bit act1 = 1'b0;
  int cur_ict = 0;
  bit cur_en = 1'b0;

  function automatic int clampv(input int v);
    return (v > 200) ? 200 : v;
  endfunction

  function automatic bit in_hi(input int ton, input int t);
    return (ton != 0) && (t < ton);
  endfunction

  function automatic bit in_lo(input int ton, input int t);
    return (ton != 0) && (t >= ton + 8) && (t < 392);
  endfunction

  // Predict outputs after the coming clock edge for the given inputs.
  task automatic model_step(input bit r, input bit e, input bit f, input int ict);
    exp_t x;
    int t0, t1, nm;
    if (r) begin
      n = 0; mode = M_IDLE; ton0 = 0; ton1 = 0; act1 = 1'b0;
    end else begin
      t0 = n % 400;
      t1 = (n + 200) % 400;
      if (t0 == 399) ton0 = clampv(ict);
      if (t1 == 399) ton1 = clampv(ict);
      nm = mode;
      if (mode == M_IDLE) nm = (e && !f) ? M_ARM : M_IDLE;
      else if (mode == M_FAULT) nm = (!e && !f) ? M_IDLE : M_FAULT;
      else if (f) nm = M_FAULT;
      else if (!e) nm = M_IDLE;
      else if (mode == M_ARM && t0 == 399) nm = M_RUN;
      act1 = (nm == M_RUN) && (act1 || (mode == M_RUN && t1 == 399));
      mode = nm;
      n++;
    end
    t0 = n % 400;
    t1 = (n + 200) % 400;
    x.t0  = 16'(t0);
    x.t1  = 16'(t1);
    x.run = (mode == M_RUN);
    x.flt = (mode == M_FAULT);
    x.hi0 = x.run && in_hi(ton0, t0);
    x.lo0 = x.run && in_lo(ton0, t0);
    x.hi1 = act1 && in_hi(ton1, t1);
    x.lo1 = act1 && in_lo(ton1, t1);
    exp_q.push_back(x);
  endtask

  task automatic cyc(input bit r, input bit e, input bit f, input int ict);
    rst = r; enable = e; fault = f; inductor_charging_time = 16'(ict);
    cur_en = e; cur_ict = ict;
    model_step(r, e, f, ict);
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int cnt, input bit e, input int ict);
    for (int i = 0; i < cnt; i++) cyc(1'b0, e, 1'b0, ict);
  endtask

  // Advance until the timer (as predicted by the model) reads val; bounded by one period.
  task automatic run_to(input int val, input bit e, input int ict);
    for (int i = 0; i < 400 && (n % 400) != val; i++) cyc(1'b0, e, 1'b0, ict);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation once per cycle.
  initial begin
    exp_t x, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        a = {timer_buck_4us_0, timer_buck_4us_1, gate_hi_0, gate_lo_0,
             gate_hi_1, gate_lo_1, running, fault_latched};
        checks++;
        if (a !== x) begin
          errors++;
          $display("FAIL outputs @%0t: got t0=%0d t1=%0d hi0/lo0/hi1/lo1=%b%b%b%b run=%b flt=%b, want t0=%0d t1=%0d hi0/lo0/hi1/lo1=%b%b%b%b run=%b flt=%b",
                   $time, a.t0, a.t1, a.hi0, a.lo0, a.hi1, a.lo1, a.run, a.flt,
                   x.t0, x.t1, x.hi0, x.lo0, x.hi1, x.lo1, x.run, x.flt);
        end
      end
    end
  end

  initial begin
    int ict;
    bit e;
    // reset and idle timebase
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 400)));
    // fault in IDLE blocks ARM but does not latch
    cyc(1'b0, 1'b1, 1'b1, 100);
    cyc(1'b0, 1'b1, 1'b1, 100);
    // enable dropped on the ARM->RUN wrap cycle
    run_to(399, 1'b1, 100);
    cyc(1'b0, 1'b0, 1'b0, 100);
    run_n(5, 1'b0, 100);
    // nominal run, then clamp and diode mode
    run_n(1300, 1'b1, 100);
    run_n(800, 1'b1, 350);
    run_n(800, 1'b1, 0);
    // on-time change mid-period
    run_n(800, 1'b1, 100);
    run_to(150, 1'b1, 100);
    run_n(600, 1'b1, 50);
    // one-cycle fault pulse during RUN, then recovery sequence
    run_n(400, 1'b1, 100);
    run_to(50, 1'b1, 100);
    cyc(1'b0, 1'b1, 1'b1, 100);
    run_n(500, 1'b1, 100);
    run_n(3, 1'b0, 100);
    run_n(900, 1'b1, 100);
    // reset while gate_hi_0 is high
    run_to(30, 1'b1, 100);
    cyc(1'b1, 1'b1, 1'b0, 100);
    run_n(10, 1'b0, 100);
    // randomized traffic
    e = 1'b1; ict = 120;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 599) == 0) e = ~e;
      if ($urandom_range(0, 49) == 0) ict = int'($urandom_range(0, 400));
      cyc(($urandom_range(0, 2999) == 0), e, ($urandom_range(0, 1499) == 0), ict);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
